// File: rtl/muldiv_seq.sv
`timescale 1ns/1ps
// Iterative multiply/divide unit: shift-add multiply, restoring divide, sign fix-up, HI/LO results.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU complete at once with div_by_zero as an unsupported-op flag.
module muldiv_seq #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic                 a_sign_q, a_sign_d;
    logic                 b_sign_q, b_sign_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dbz_q, dbz_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   prod_fix;

`ifdef MULDIV_DIV_EN
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH:0]       rem_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     new_rem;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo_fix, rem_fix, a_orig;
`endif

    // Signed ops run on magnitudes; the signs are kept for the FIX step.
    always_comb begin
        a_neg = ~op[0] & reg_a[WIDTH-1];
        b_neg = ~op[0] & reg_b[WIDTH-1];
        a_abs = a_neg ? -reg_a : reg_a;
        b_abs = b_neg ? -reg_b : reg_b;
    end

    // {upper, multiplier}: add the multiplicand on a set LSB, then shift right with the carry.
    always_comb begin
        mul_addend = acc_q[0] ? opa_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
        prod_fix   = (a_sign_q ^ b_sign_q) ? -acc_q : acc_q;
    end

`ifdef MULDIV_DIV_EN
    // {remainder, dividend/quotient}: the partial remainder needs one extra bit after the shift.
    always_comb begin
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = rem_shift >= {1'b0, opb_q};
        new_rem   = div_ge ? (rem_shift[WIDTH-1:0] - opb_q) : rem_shift[WIDTH-1:0];
        div_next  = {new_rem, acc_q[WIDTH-2:0], div_ge};
        quo_fix   = (a_sign_q ^ b_sign_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = a_sign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        a_orig    = a_sign_q ? -opa_q : opa_q;
    end
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
`ifdef MULDIV_DIV_EN
        is_div_d = is_div_q;
        opb_d    = opb_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d    = a_abs;
                    a_sign_d = a_neg;
                    b_sign_d = b_neg;
                    dbz_d    = 1'b0;
`ifdef MULDIV_DIV_EN
                    is_div_d = op[1];
                    opb_d    = b_abs;
                    acc_d    = op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                    count_d  = CNT_W'(WIDTH);
                    state_d  = RUN;
`else
                    if (op[1]) begin
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, b_abs};
                        count_d = CNT_W'(WIDTH);
                        state_d = RUN;
                    end
`endif
                end
            end
            RUN: begin
`ifdef MULDIV_DIV_EN
                acc_d = is_div_q ? div_next : mul_next;
`else
                acc_d = mul_next;
`endif
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    if (opb_q == '0) begin
                        hi_d  = a_orig;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
`else
                {hi_d, lo_d} = prod_fix;
`endif
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            opb_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
            opb_q    <= opb_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for muldiv_seq: a stimulus process queues expected results from an arithmetic model, a monitor checks each done.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] reg_a = '0;
    logic [W-1:0] reg_b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
        int           n;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           edge_cnt = 0;
    logic         rst_at_edge = 1'b1;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;
    int           busy_run = 0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt++;
        rst_at_edge = rst;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: MIPS HI/LO semantics straight from 64-bit integer arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         r;
        longint       sa, sb, q, m;
        logic [63:0]  p;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        r.dbz = 1'b0;
        r.lat = W + 2;
        r.n   = 0;
        r.hi  = '0;
        r.lo  = '0;
        case (o)
            2'b00: begin
                p    = sa * sb;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'b01: begin
                p    = 64'(a) * 64'(b);
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == '0) begin
                    r.hi  = a;
                    r.lo  = '1;
                    r.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    q    = sa / sb;
                    m    = sa % sb;
                    r.lo = q[31:0];
                    r.hi = m[31:0];
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
`else
                r.hi  = last_hi;
                r.lo  = last_lo;
                r.dbz = 1'b1;
                r.lat = 1;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0: v = '0;
            1: v = 32'd1;
            2: v = '1;
            3: v = 32'h8000_0000;
            4: v = 32'(40'($urandom_range(0, 255)));
            5: v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issues one start once the unit is idle; optional spam keeps start high with junk while busy.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int spam, input bit keep);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        while (busy !== 1'b0) begin
            if (waited > 300) begin
                checks++;
                errors++;
                $display("[TB] FAIL idle_wait: busy still %b after %0d cycles, required 0", busy, waited);
                return;
            end
            waited++;
            @(negedge clk);
        end
        e     = model(o, a, b);
        op    = o;
        reg_a = a;
        reg_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.n = edge_cnt;
        if (keep) begin
            sb_q.push_back(e);
            last_hi = e.hi;
            last_lo = e.lo;
        end
        start = 1'b0;
        for (int i = 0; i < spam; i++) begin
            @(negedge clk);
            start = 1'b1;
            op    = 2'($urandom_range(0, 3));
            reg_a = $urandom;
            reg_b = $urandom;
        end
        if (spam > 0) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Monitor: every done pops one expectation; otherwise hi/lo must hold.
    always @(negedge clk) begin
        exp_t e;
        busy_run = (busy === 1'b1) ? busy_run + 1 : 0;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: done=1 with hi=0x%0h lo=0x%0h, required no pending op", hi, lo);
            end else begin
                e = sb_q.pop_front();
                checkOutput("hi", 64'(hi), 64'(e.hi));
                checkOutput("lo", 64'(lo), 64'(e.lo));
                checkOutput("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                checkOutput("latency", 64'(edge_cnt - e.n + 1), 64'(e.lat));
                checkOutput("busy_cycles", 64'(busy_run), 64'(e.lat));
            end
        end else if (!rst_at_edge) begin
            checkOutput("hold_hi", 64'(hi), 64'(prev_hi));
            checkOutput("hold_lo", 64'(lo), 64'(prev_lo));
        end
        prev_hi = hi;
        prev_lo = lo;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   t;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;

        $display("[TB] directed operations");
        applyStimulus(2'b00, 32'd10, 32'hFFFF_FFFC, 0, 1'b1);
        applyStimulus(2'b01, 32'd65536, 32'd131072, 0, 1'b1);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);
        applyStimulus(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 1'b1);
        applyStimulus(2'b11, 32'hFFFF_FFFF, 32'd16, 0, 1'b1);
        applyStimulus(2'b11, 32'd25, 32'd0, 0, 1'b1);
        applyStimulus(2'b01, 32'd3, 32'd3, 0, 1'b1);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        applyStimulus(2'b10, 32'd9, 32'd3, 0, 1'b1);
        applyStimulus(2'b10, 32'hFFFF_FFF0, 32'd0, 0, 1'b1);

        $display("[TB] start held during a multiply");
        applyStimulus(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 20, 1'b1);

        $display("[TB] reset in mid-operation");
        applyStimulus(2'b00, 32'd123, 32'd456, 0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_hi", 64'(hi), 64'd0);
        checkOutput("abort_lo", 64'(lo), 64'd0);
        checkOutput("abort_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        last_hi = '0;
        last_lo = '0;

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            applyStimulus(ro, ra, rb, (ro[1] == 1'b0 && $urandom_range(0, 3) == 0) ? 10 : 0, 1'b1);
        end

        t = 0;
        while (sb_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d results still pending, required 0", sb_q.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS datapath.
- Produces the 2*WIDTH-bit product, or the quotient and remainder, into HI/LO result registers.
- Sits beside the combinational ALU and is launched by the controller for MULT/MULTU/DIV/DIVU.
- The controller stalls on busy and samples hi/lo after done.

Parameters:
- WIDTH, 32: operand width; hi and lo are each WIDTH bits; WIDTH >= 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  launch request; sampled only in IDLE.
- op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- reg_a  input  WIDTH  multiplicand / dividend; captured on accepted start.
- reg_b  input  WIDTH  multiplier / divisor; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse; hi/lo valid from this cycle on.
- hi  output  WIDTH  product upper half / remainder.
- lo  output  WIDTH  product lower half / quotient.
- div_by_zero  output  1  set with done when a DIV/DIVU divisor is 0; cleared on the next accepted start.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high on clk/rst.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0.
- rst mid-operation aborts immediately; hi/lo return to 0; no done pulse.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 captures op and the operands; signed ops capture absolute values and record the result signs.
  - Transition to RUN with counter=WIDTH.
- RUN:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
  - Counter decrements; leave for FIX when the counter reaches 1→0, giving exactly WIDTH RUN cycles.
- FIX:
  - Applies two's-complement negation for signed ops.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign, so truncation is toward zero.
  - Go to DONE.
- DONE: hi/lo registers update, done=1 for this cycle, then IDLE.
- Latency: start accepted at edge N; done high in cycle N+WIDTH+2. Back-to-back start is accepted in the cycle after DONE.
- Ignored starts: start while busy has no effect and is not queued.
- hi/lo hold: hi/lo hold their last value until the next DONE; they never show intermediate values.
- Divide by zero:
  - Full latency is still taken.
  - Result is hi=reg_a (as captured), lo=all ones, div_by_zero=1.
- Signed overflow: DIV of -2^(WIDTH-1) by -1 gives lo=-2^(WIDTH-1) (wrap), hi=0, no flag.
- Arithmetic: multiply accumulator is 2*WIDTH bits, all unsigned internally; no carry out of the 2*WIDTH result.

Optional Feature:
- Macro: MULDIV_DIV_EN.
- Defined: DIV/DIVU are supported as above.
- Undefined:
  - The divide datapath is removed.
  - DIV/DIVU with start go IDLE→DONE directly, so done is high in cycle N+1.
  - hi/lo are unchanged and div_by_zero=1, which acts as an unsupported-op flag.
  - MULT/MULTU behaviour is unchanged.

Test Plan:
- Reset, then MULT with reg_a=10, reg_b=-4 → done at N+34 (WIDTH=32); hi=0xFFFFFFFF, lo=0xFFFFFFD8; busy high for exactly 34 cycles.
- MULTU with reg_a=65536, reg_b=131072 → hi=0x00000002, lo=0x00000000. MULTU 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV:
  - -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 7/-2 → lo=0xFFFFFFFD, hi=0x00000001.
  - DIVU 0xFFFFFFFF/16 → lo=0x0FFFFFFF, hi=0x0000000F.
- DIVU 25/0 → done at N+34, div_by_zero=1, hi=25, lo=0xFFFFFFFF. Next MULTU 3*3 clears the flag and gives lo=9.
- Start pulsed every cycle during a MULT → only the first is accepted. Assert rst at cycle N+10 → no done; hi=lo=0; busy=0 on the next cycle.
- DIV 0x80000000/-1 → lo=0x80000000, hi=0, div_by_zero=0. With MULDIV_DIV_EN undefined: DIV 9/3 → done at N+1, hi/lo unchanged, div_by_zero=1.
